namco_io_seq: RTL and testbench



---
 rtl/namco_io_pkg.sv | 27 ++
 rtl/namco_bcd8.sv | 20 ++
 rtl/namco_io_seq.sv | 223 ++++++++++++++++++++++
 tb/tb_namco_io_seq.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/namco_io_pkg.sv
// Shared definitions for the Namco custom I/O emulator: mode encodings,
// control-nibble addresses and the sequencer state type.
package namco_io_pkg;

  localparam logic [3:0] MODE_RAW    = 4'd0;
  localparam logic [3:0] MODE_CREDIT = 4'd1;
  localparam logic [3:0] MODE_DIP    = 4'd2;
  localparam logic [3:0] MODE_NONE   = 4'd3;

  localparam int ADDR_MODE = 8;
  localparam int ADDR_CPC  = 9;
  localparam int ADDR_PPC  = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_COIN,
    ST_START,
    ST_WRITE
  } seq_state_e;

  // A ratio nibble of zero behaves as one.
  function automatic logic [3:0] ratio_eff(input logic [3:0] n);
    return (n == 4'd0) ? 4'd1 : n;
  endfunction

endpackage

// File: rtl/namco_bcd8.sv
// Binary to two-digit BCD by combinational double-dabble; the hundreds
// digit is discarded because the credit count never exceeds 99.
module namco_bcd8 (
  input  logic [7:0] bin_i,
  output logic [7:0] bcd_o
);

  logic [7:0] dig;

  always_comb begin
    dig = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      if (dig[3:0] >= 4'd5) dig[3:0] = dig[3:0] + 4'd3;
      if (dig[7:4] >= 4'd5) dig[7:4] = dig[7:4] + 4'd3;
      dig = {dig[6:0], bin_i[i]};
    end
    bcd_o = dig;
  end

endmodule

// File: rtl/namco_io_seq.sv
// Namco custom I/O chip: CPU-shared nibble RAM plus a once-per-frame
// sequencer that samples inputs, keeps BCD credits and writes results back.
module namco_io_seq
  import namco_io_pkg::*;
#(
  parameter int NPLAYERS   = 2,
  parameter int NCOINS     = 2,
  parameter int AW         = 6,
  parameter int NDIP       = 6,
  parameter int CREDIT_MAX = 99
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  UPDATE,
  input  logic                  ENABLE,
  input  logic                  WR,
  input  logic [AW-1:0]         ADRS,
  input  logic [7:0]            IN,
  output logic [7:0]            OUT,
  input  logic [6*NPLAYERS-1:0] STKTRG,
  input  logic [NCOINS-1:0]     COIN,
  input  logic [NPLAYERS-1:0]   START,
  input  logic [4*NDIP-1:0]     DIPSW,
  output logic [7:0]            CREDITS,
  output logic                  BUSY,
  output seq_state_e            dbg_state_o
);

  localparam int IW    = 2;
  localparam int NWMAX = (2 + 2*NPLAYERS > NDIP) ? 2 + 2*NPLAYERS : NDIP;
  localparam int WW    = $clog2(NWMAX);

  logic [3:0] mem [2**AW];

  seq_state_e state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic [7:0] credits_q, credits_d;
  logic [3:0] acc_q, acc_d;
  logic upd_prev_q;
  logic [3:0] mode_q, cpc_q, ppc_q;
  logic [NCOINS-1:0] coin_raw_q, coin_prev_q, coin_edge_q;
  logic [NPLAYERS-1:0] start_raw_q, start_prev_q, start_edge_q;
  logic [6*NPLAYERS-1:0] stk_q;
  logic [2*NPLAYERS-1:0] trg_now, trg_prev_q, trg_edge_q;
  logic [4*NDIP-1:0] dip_q;
  logic [7:0] out_q;
  logic [7:0] credits_bcd;
  logic cpu_we, seq_we, latch_en, coin_hit, start_hit, last_wr;
  logic [WW:0] nwr;
  logic [3:0] wr_data, cpc_eff, ppc_eff;
  logic [8:0] credit_sum;
  logic [7:0] credit_need, credit_sat;
  logic unused_in;

  // CPU bus: a cycle with ENABLE high is a transfer with no wait states; WR
  // selects write. The CPU always wins the RAM port, the sequencer retries.
  assign cpu_we      = ENABLE & WR;
  assign unused_in   = ^IN[7:4];
  assign OUT         = out_q;
  assign CREDITS     = credits_bcd;
  assign BUSY        = (state_q != ST_IDLE);
  assign dbg_state_o = state_q;

  namco_bcd8 u_bcd (
    .bin_i (credits_q),
    .bcd_o (credits_bcd)
  );

  always_comb begin
    for (int p = 0; p < NPLAYERS; p++) trg_now[2*p +: 2] = STKTRG[6*p+4 +: 2];
  end

  assign cpc_eff     = ratio_eff(cpc_q);
  assign ppc_eff     = ratio_eff(ppc_q);
  assign credit_sum  = {1'b0, credits_q} + {5'b0, ppc_eff};
  assign credit_sat  = (credit_sum > 9'(CREDIT_MAX)) ? 8'(CREDIT_MAX) : credit_sum[7:0];
  assign credit_need = {{(8-IW){1'b0}}, idx_q} + 8'd1;

  always_comb begin
    case (mode_q)
      MODE_RAW, MODE_CREDIT: nwr = (WW+1)'(2 + 2*NPLAYERS);
      MODE_DIP:              nwr = (WW+1)'(NDIP);
      default:               nwr = '0;
    endcase
  end

  assign last_wr = ({1'b0, wcnt_q} == nwr - (WW+1)'(1));

  always_comb begin
    coin_hit  = 1'b0;
    start_hit = 1'b0;
    for (int i = 0; i < NCOINS; i++)   if (idx_q == IW'(i)) coin_hit  = coin_edge_q[i];
    for (int i = 0; i < NPLAYERS; i++) if (idx_q == IW'(i)) start_hit = start_edge_q[i];
  end

  always_comb begin
    wr_data = 4'h0;
    if (mode_q == MODE_DIP) begin
      for (int w = 0; w < NDIP; w++) if (wcnt_q == WW'(w)) wr_data = dip_q[4*w +: 4];
    end else begin
      if (wcnt_q == WW'(0))
        wr_data = (mode_q == MODE_CREDIT) ? credits_bcd[7:4] : 4'(coin_raw_q);
      if (wcnt_q == WW'(1))
        wr_data = (mode_q == MODE_CREDIT) ? credits_bcd[3:0] : 4'(start_raw_q);
      for (int p = 0; p < NPLAYERS; p++) begin
        if (wcnt_q == WW'(2 + 2*p)) wr_data = stk_q[6*p +: 4];
        if (wcnt_q == WW'(3 + 2*p))
          wr_data = (mode_q == MODE_CREDIT) ?
                    {trg_edge_q[2*p+1], trg_edge_q[2*p], stk_q[6*p+5], stk_q[6*p+4]} :
                    {2'b00, stk_q[6*p+5], stk_q[6*p+4]};
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    wcnt_d    = wcnt_q;
    credits_d = credits_q;
    acc_d     = acc_q;
    latch_en  = 1'b0;
    seq_we    = 1'b0;
    case (state_q)
      ST_IDLE: if (UPDATE && !upd_prev_q) state_d = ST_LATCH;
      ST_LATCH: begin
        latch_en = 1'b1;
        idx_d    = '0;
        state_d  = ST_COIN;
      end
      ST_COIN: begin
        if (mode_q == MODE_CREDIT && coin_hit) begin
          if (({1'b0, acc_q} + 5'd1) >= {1'b0, cpc_eff}) begin
            credits_d = credit_sat;
            acc_d     = 4'd0;
          end else begin
            acc_d = acc_q + 4'd1;
          end
        end
        if (idx_q == IW'(NCOINS-1)) begin
          idx_d   = '0;
          state_d = ST_START;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      ST_START: begin
        if (mode_q == MODE_CREDIT && start_hit && credits_q >= credit_need)
          credits_d = credits_q - credit_need;
        if (idx_q == IW'(NPLAYERS-1)) begin
          idx_d   = '0;
          wcnt_d  = '0;
          state_d = (nwr == '0) ? ST_IDLE : ST_WRITE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      ST_WRITE: begin
        if (!cpu_we) begin
          seq_we = 1'b1;
          if (last_wr) state_d = ST_IDLE;
          else         wcnt_d  = wcnt_q + WW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      wcnt_q       <= '0;
      credits_q    <= '0;
      acc_q        <= '0;
      upd_prev_q   <= 1'b0;
      mode_q       <= MODE_NONE;
      cpc_q        <= '0;
      ppc_q        <= '0;
      coin_raw_q   <= '0;
      coin_prev_q  <= '0;
      coin_edge_q  <= '0;
      start_raw_q  <= '0;
      start_prev_q <= '0;
      start_edge_q <= '0;
      stk_q        <= '0;
      trg_prev_q   <= '0;
      trg_edge_q   <= '0;
      dip_q        <= '0;
      out_q        <= 8'hF0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      wcnt_q     <= wcnt_d;
      credits_q  <= credits_d;
      acc_q      <= acc_d;
      upd_prev_q <= UPDATE;
      if (ENABLE) out_q <= {4'hF, mem[ADRS]};
      if (latch_en) begin
        mode_q       <= mem[AW'(ADDR_MODE)];
        cpc_q        <= mem[AW'(ADDR_CPC)];
        ppc_q        <= mem[AW'(ADDR_PPC)];
        coin_raw_q   <= COIN;
        coin_edge_q  <= COIN & ~coin_prev_q;
        coin_prev_q  <= COIN;
        start_raw_q  <= START;
        start_edge_q <= START & ~start_prev_q;
        start_prev_q <= START;
        stk_q        <= STKTRG;
        trg_edge_q   <= trg_now & ~trg_prev_q;
        trg_prev_q   <= trg_now;
        dip_q        <= DIPSW;
      end
    end
  end

  // RAM keeps its contents through reset.
  always_ff @(posedge CLK) begin
    if (cpu_we)                 mem[ADRS]         <= IN[3:0];
    else if (seq_we && !RESET)  mem[AW'(wcnt_q)]  <= wr_data;
  end

endmodule

// File: tb/tb_namco_io_seq.sv
// Directed bench for namco_io_seq: credit counting, ratios, saturation,
// write modes, CPU-write stalls and mid-sequence reset.
module tb_namco_io_seq;
  import namco_io_pkg::*;

  logic        CLK = 1'b0;
  logic        RESET, UPDATE, ENABLE, WR;
  logic [5:0]  ADRS;
  logic [7:0]  IN, OUT;
  logic [11:0] STKTRG;
  logic [1:0]  COIN, START;
  logic [23:0] DIPSW;
  logic [7:0]  CREDITS;
  logic        BUSY;
  seq_state_e  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [3:0] exp_q[$];
  logic [3:0] rd;
  int n, g, k;

  namco_io_seq dut (
    .CLK(CLK), .RESET(RESET), .UPDATE(UPDATE), .ENABLE(ENABLE), .WR(WR),
    .ADRS(ADRS), .IN(IN), .OUT(OUT), .STKTRG(STKTRG), .COIN(COIN),
    .START(START), .DIPSW(DIPSW), .CREDITS(CREDITS), .BUSY(BUSY),
    .dbg_state_o(dbg_state)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic ram_wr(input logic [5:0] a, input logic [3:0] d);
    @(negedge CLK);
    ENABLE = 1'b1; WR = 1'b1; ADRS = a; IN = {4'hA, d};
    @(negedge CLK);
    ENABLE = 1'b0; WR = 1'b0;
  endtask

  task automatic check_ram(input string tag, input logic [5:0] a, input logic [3:0] exp);
    @(negedge CLK);
    ENABLE = 1'b1; WR = 1'b0; ADRS = a;
    @(negedge CLK);
    ENABLE = 1'b0;
    check_eq(tag, {24'h0, OUT}, {24'h0, 4'hF, exp});
  endtask

  task automatic frame(output int len);
    @(negedge CLK) UPDATE = 1'b1;
    @(negedge CLK) UPDATE = 1'b0;
    len = 0;
    while (BUSY && len < 100) begin
      len++;
      @(negedge CLK);
    end
    check_eq("frame_done", {31'h0, BUSY}, 32'h0);
  endtask

  task automatic coin_pulse();
    int l;
    COIN = 2'b01;
    frame(l);
    COIN = 2'b00;
    frame(l);
  endtask

  task automatic do_reset();
    @(negedge CLK) RESET = 1'b1;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
  endtask

  initial begin
    RESET = 1'b1; UPDATE = 1'b0; ENABLE = 1'b0; WR = 1'b0; ADRS = '0; IN = '0;
    STKTRG = '0; COIN = '0; START = '0; DIPSW = '0;
    repeat (3) @(negedge CLK);
    check_eq("rst_out", {24'h0, OUT}, 32'hF0);
    check_eq("rst_credits", {24'h0, CREDITS}, 32'h0);
    check_eq("rst_busy", {31'h0, BUSY}, 32'h0);
    RESET = 1'b0;

    // Mode 1, ratio 1/1 (coins-per-credit nibble 0 means 1)
    ram_wr(6'd8, 4'd1); ram_wr(6'd9, 4'd0); ram_wr(6'd10, 4'd1);
    repeat (3) coin_pulse();
    check_eq("three_coins", {24'h0, CREDITS}, 32'h03);
    STKTRG = 12'hA95; START = 2'b01;
    frame(n);
    check_eq("mode1_len", n, 11);
    check_eq("start_p1", {24'h0, CREDITS}, 32'h02);
    START = 2'b00;
    check_ram("m1_tens", 6'd0, 4'h0);
    check_ram("m1_ones", 6'd1, 4'h2);
    check_ram("m1_p0_dir", 6'd2, 4'h5);
    check_ram("m1_p0_trg", 6'd3, 4'h5);
    check_ram("m1_p1_dir", 6'd4, 4'hA);
    check_ram("m1_p1_trg", 6'd5, 4'hA);
    frame(n);
    check_ram("m1_p0_trg_held", 6'd3, 4'h1);
    check_ram("m1_p1_trg_held", 6'd5, 4'h2);
    STKTRG = '0;

    // Ratio 2 coins / 3 credits, then saturation
    do_reset();
    check_eq("reset_credits", {24'h0, CREDITS}, 32'h0);
    check_ram("ram_kept", 6'd8, 4'h1);
    ram_wr(6'd9, 4'd2); ram_wr(6'd10, 4'd3);
    repeat (3) coin_pulse();
    check_eq("ratio_2_3", {24'h0, CREDITS}, 32'h03);
    coin_pulse();
    check_eq("acc_carry", {24'h0, CREDITS}, 32'h06);
    ram_wr(6'd9, 4'd1); ram_wr(6'd10, 4'hF);
    repeat (6) coin_pulse();
    check_eq("ratio_1_15", {24'h0, CREDITS}, 32'h96);
    ram_wr(6'd10, 4'd2);
    coin_pulse();
    check_eq("credits_98", {24'h0, CREDITS}, 32'h98);
    ram_wr(6'd10, 4'd3);
    coin_pulse();
    check_eq("saturate", {24'h0, CREDITS}, 32'h99);
    coin_pulse();
    check_eq("saturate_hold", {24'h0, CREDITS}, 32'h99);
    check_ram("sat_tens", 6'd0, 4'h9);
    check_ram("sat_ones", 6'd1, 4'h9);

    // Coin and player-2 start in one frame: coin counted first
    do_reset();
    ram_wr(6'd9, 4'd1); ram_wr(6'd10, 4'd1);
    coin_pulse();
    check_eq("one_credit", {24'h0, CREDITS}, 32'h01);
    COIN = 2'b01; START = 2'b10;
    frame(n);
    COIN = 2'b00; START = 2'b00;
    frame(n);
    check_eq("coin_then_start2", {24'h0, CREDITS}, 32'h00);
    START = 2'b10;
    frame(n);
    START = 2'b00;
    frame(n);
    check_eq("no_underflow", {24'h0, CREDITS}, 32'h00);

    // UPDATE edge while busy is dropped
    COIN = 2'b01;
    @(negedge CLK) UPDATE = 1'b1;
    @(negedge CLK) UPDATE = 1'b0;
    @(negedge CLK) UPDATE = 1'b1;
    @(negedge CLK) UPDATE = 1'b0;
    g = 0;
    while (BUSY && g < 100) begin g++; @(negedge CLK); end
    check_eq("busy_end", {31'h0, BUSY}, 32'h0);
    repeat (3) @(negedge CLK);
    check_eq("no_requeue", {31'h0, BUSY}, 32'h0);
    COIN = 2'b00;
    check_eq("single_count", {24'h0, CREDITS}, 32'h01);

    // CPU writes on three WRITE cycles stall the sequencer
    @(negedge CLK) UPDATE = 1'b1;
    @(negedge CLK) UPDATE = 1'b0;
    n = 0; k = 0;
    while (BUSY && n < 100) begin
      n++;
      if (dbg_state == ST_WRITE && k < 3) begin
        ENABLE = 1'b1; WR = 1'b1; ADRS = 6'(20 + k); IN = 8'(8'h57 + k);
        k++;
      end else begin
        ENABLE = 1'b0; WR = 1'b0;
      end
      @(negedge CLK);
    end
    ENABLE = 1'b0; WR = 1'b0;
    check_eq("stall_len", n, 14);
    check_ram("cpu_w0", 6'd20, 4'h7);
    check_ram("cpu_w1", 6'd21, 4'h8);
    check_ram("cpu_w2", 6'd22, 4'h9);
    check_ram("stall_tens", 6'd0, 4'h0);
    check_ram("stall_ones", 6'd1, 4'h1);
    check_ram("stall_p1_trg", 6'd5, 4'h0);

    // Reset during COIN, then a held coin counts exactly once
    COIN = 2'b01;
    @(negedge CLK) UPDATE = 1'b1;
    @(negedge CLK) UPDATE = 1'b0;
    g = 0;
    while (dbg_state != ST_COIN && g < 20) begin g++; @(negedge CLK); end
    check_eq("reach_coin", 32'(dbg_state), 32'(ST_COIN));
    RESET = 1'b1;
    @(negedge CLK);
    check_eq("abort_busy", {31'h0, BUSY}, 32'h0);
    check_eq("abort_credits", {24'h0, CREDITS}, 32'h0);
    check_eq("abort_out", {24'h0, OUT}, 32'hF0);
    RESET = 1'b0;
    frame(n);
    check_eq("held_coin", {24'h0, CREDITS}, 32'h01);
    frame(n);
    check_eq("held_coin_once", {24'h0, CREDITS}, 32'h01);
    COIN = 2'b00;

    // Mode 0 raw levels; coin edge does not count
    ram_wr(6'd8, 4'd0);
    COIN = 2'b10; START = 2'b01; STKTRG = 12'h033;
    frame(n);
    COIN = '0; START = '0; STKTRG = '0;
    check_eq("mode0_len", n, 11);
    check_eq("mode0_credits", {24'h0, CREDITS}, 32'h01);
    check_ram("m0_coin", 6'd0, 4'h2);
    check_ram("m0_start", 6'd1, 4'h1);
    check_ram("m0_p0_dir", 6'd2, 4'h3);
    check_ram("m0_p0_trg", 6'd3, 4'h3);
    check_ram("m0_p1_dir", 6'd4, 4'h0);

    // Mode 2 DIP readout
    ram_wr(6'd8, 4'd2);
    DIPSW = 24'h654321;
    frame(n);
    check_eq("mode2_len", n, 11);
    for (int i = 0; i < 6; i++) exp_q.push_back(4'(i + 1));
    for (int i = 0; i < 6; i++) check_ram("dip_ram", 6'(i), exp_q.pop_front());

    // Mode 3: no writes
    ram_wr(6'd8, 4'd3);
    DIPSW = 24'hABCDEF;
    frame(n);
    check_eq("mode3_len", n, 5);
    for (int i = 0; i < 6; i++) exp_q.push_back(4'(i + 1));
    for (int i = 0; i < 6; i++) check_ram("mode3_ram", 6'(i), exp_q.pop_front());

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
